seq_signed_multiplier: RTL and testbench

Parametrised iterative shift-and-add multiplier that produces a full-width 2*WIDTH-bit product from two WIDTH-bit operands.
- Selectable signed (two's complement) or unsigned operation per transaction.
- Start/busy/done handshake; one multiplier bit is consumed per clock.
- Area-efficient replacement for combinational small-width multipliers in datapaths that tolerate WIDTH+1 cycles of latency.

---
 rtl/seq_signed_multiplier.sv | 125 ++++++++++++
 tb/tb_seq_signed_multiplier.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_signed_multiplier.sv
// Iterative shift-and-add multiplier producing a full 2*WIDTH-bit product.
// Signed (two's complement) or unsigned operation is selected per transaction.
// Signed operands are reduced to magnitudes, multiplied unsigned, and the
// product sign is restored in a final fix-up cycle.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request a multiplication (sampled only while idle)
//   signed_mode  1 = two's complement operands, 0 = unsigned (sampled with start)
//   a            multiplicand (sampled with start)
//   b            multiplier (sampled with start)
//   busy         high while a multiplication is in progress
//   done         single-cycle pulse: p holds a new result
//   p            product, held stable between done pulses
module seq_signed_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  localparam int unsigned ProdW = 2 * WIDTH;
  localparam int unsigned CntW  = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e             state_q, state_d;
  logic [ProdW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [ProdW-1:0]   acc_q, acc_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic [ProdW-1:0]   p_q, p_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   mag_a, mag_b;

  // The most-negative operand negates to 2^(WIDTH-1), which still fits as
  // an unsigned WIDTH-bit magnitude, so no extra bit is needed.
  always_comb begin
    mag_a = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    mag_b = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    p_d      = p_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d  = ProdW'(mag_a);
          mplier_d = mag_b;
          neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StCalc;
        end
      end
      StCalc: begin
        // Multiplicand shifts up as the multiplier shifts down, so bit 0 of
        // mplier_q always pairs with the correctly weighted multiplicand.
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        // Negating a zero accumulator yields zero, so no negative zero.
        p_d     = neg_q ? (~acc_q + ProdW'(1)) : acc_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      p_q      <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      p_q      <= p_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign p    = p_q;

endmodule

// File: tb/tb_seq_signed_multiplier.sv
module tb_seq_signed_multiplier;

  logic        clk;
  logic        rst_n;

  logic        start4, sm4;
  logic [3:0]  a4, b4;
  logic        busy4, done4;
  logic [7:0]  p4;

  logic        start8, sm8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] p8;

  int checks = 0;
  int errors = 0;
  int done4_cnt = 0;

  logic [7:0]  exp4_q[$];
  logic [15:0] exp8_q[$];

  seq_signed_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(sm4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .p(p4)
  );

  seq_signed_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .p(p8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (done4 === 1'b1) done4_cnt <= done4_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] ref4(input logic sm, input logic [3:0] x, input logic [3:0] y);
    int ix, iy, r;
    ix = sm ? int'($signed(x)) : int'(x);
    iy = sm ? int'($signed(y)) : int'(y);
    r = ix * iy;
    return r[7:0];
  endfunction

  function automatic logic [15:0] ref8(input logic sm, input logic [7:0] x, input logic [7:0] y);
    int ix, iy, r;
    ix = sm ? int'($signed(x)) : int'(x);
    iy = sm ? int'($signed(y)) : int'(y);
    r = ix * iy;
    return r[15:0];
  endfunction

  // Starts an op on the WIDTH=4 instance (must be idle) and waits for done.
  // Returns the product and the cycle count from acceptance to done.
  task automatic run4(input logic sm, input logic [3:0] aa, input logic [3:0] bb,
                      output logic [7:0] pres, output int lat);
    sm4 = sm; a4 = aa; b4 = bb; start4 = 1'b1;
    exp4_q.push_back(ref4(sm, aa, bb));
    @(posedge clk); #1;
    start4 = 1'b0;
    lat = 0;
    while (done4 !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    pres = p4;
  endtask

  task automatic run8(input logic sm, input logic [7:0] aa, input logic [7:0] bb,
                      output logic [15:0] pres, output int lat);
    sm8 = sm; a8 = aa; b8 = bb; start8 = 1'b1;
    exp8_q.push_back(ref8(sm, aa, bb));
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    pres = p8;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (p4 !== 8'h00 || busy4 !== 1'b0 || done4 !== 1'b0) begin
      errors++;
      $display("FAIL reset4: p=%h busy=%b done=%b, required p=00 busy=0 done=0", p4, busy4, done4);
    end
    checks++;
    if (p8 !== 16'h0000 || busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL reset8: p=%h busy=%b done=%b, required p=0000 busy=0 done=0", p8, busy8, done8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_signed_basic();
    int lat;
    logic [7:0] exp;
    sm4 = 1'b1; a4 = 4'hD; b4 = 4'h5; start4 = 1'b1;
    exp4_q.push_back(ref4(1'b1, 4'hD, 4'h5));
    @(posedge clk); #1;
    start4 = 1'b0;
    checks++;
    if (busy4 !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: busy=%b, required 1", busy4);
    end
    lat = 0;
    while (done4 !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    exp = exp4_q.pop_front();
    checks++;
    if (lat !== 5 || p4 !== exp || busy4 !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: p=%h lat=%0d busy=%b, required p=%h lat=5 busy=0", p4, lat, busy4, exp);
    end
    @(posedge clk); #1;
    checks++;
    if (done4 !== 1'b0 || p4 !== exp) begin
      errors++;
      $display("FAIL basic_hold: done=%b p=%h, required done=0 p=%h", done4, p4, exp);
    end
  endtask

  task automatic test_corners4();
    logic [3:0] ta[3] = '{4'h8, 4'hF, 4'hF};
    logic [3:0] tb[3] = '{4'h8, 4'hF, 4'hF};
    logic       ts[3] = '{1'b1, 1'b0, 1'b1};
    logic [7:0] res, exp;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run4(ts[i], ta[i], tb[i], res, lat);
      exp = exp4_q.pop_front();
      checks++;
      if (res !== exp || lat !== 5) begin
        errors++;
        $display("FAIL corner4_%0d: p=%h lat=%0d, required p=%h lat=5", i, res, lat, exp);
      end
    end
  endtask

  task automatic test_width8();
    logic [7:0]  ta[3] = '{8'h80, 8'h00, 8'h80};
    logic [7:0]  tb[3] = '{8'h7F, 8'hFB, 8'h80};
    logic [15:0] res, exp;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run8(1'b1, ta[i], tb[i], res, lat);
      exp = exp8_q.pop_front();
      checks++;
      if (res !== exp || lat !== 9) begin
        errors++;
        $display("FAIL width8_%0d: p=%h lat=%0d, required p=%h lat=9", i, res, lat, exp);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start();
    int lat, dc0;
    logic [7:0] exp;
    @(posedge clk); #1;
    dc0 = done4_cnt;
    sm4 = 1'b1; a4 = 4'h2; b4 = 4'h3; start4 = 1'b1;
    exp4_q.push_back(ref4(1'b1, 4'h2, 4'h3));
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    sm4 = 1'b0; a4 = 4'h7; b4 = 4'h9; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    lat = 3;
    while (done4 !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    exp = exp4_q.pop_front();
    checks++;
    if (p4 !== exp || lat !== 5) begin
      errors++;
      $display("FAIL ignore_result: p=%h lat=%0d, required p=%h lat=5", p4, lat, exp);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (done4_cnt - dc0 !== 1 || busy4 !== 1'b0) begin
      errors++;
      $display("FAIL ignore_pulses: done pulses=%0d busy=%b, required 1 and busy=0", done4_cnt - dc0, busy4);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] res, exp, prev;
    int lat;
    run4(1'b1, 4'h5, 4'hE, res, lat);
    exp = exp4_q.pop_front();
    checks++;
    if (res !== exp || lat !== 5) begin
      errors++;
      $display("FAIL b2b_first: p=%h lat=%0d, required p=%h lat=5", res, lat, exp);
    end
    prev = exp;
    // Still in the done cycle: start here must be accepted with no idle gap.
    sm4 = 1'b1; a4 = 4'h3; b4 = 4'h2; start4 = 1'b1;
    exp4_q.push_back(ref4(1'b1, 4'h3, 4'h2));
    @(posedge clk); #1;
    start4 = 1'b0;
    checks++;
    if (busy4 !== 1'b1 || p4 !== prev || done4 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b p=%h done=%b, required busy=1 p=%h done=0", busy4, p4, done4, prev);
    end
    lat = 0;
    while (done4 !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    exp = exp4_q.pop_front();
    checks++;
    if (p4 !== exp || lat !== 5) begin
      errors++;
      $display("FAIL b2b_second: p=%h lat=%0d, required p=%h lat=5", p4, lat, exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] res, exp;
    int lat, dc0;
    @(posedge clk); #1;
    dc0 = done4_cnt;
    sm4 = 1'b1; a4 = 4'h6; b4 = 4'h5; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (p4 !== 8'h00 || busy4 !== 1'b0 || done4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: p=%h busy=%b done=%b, required p=00 busy=0 done=0", p4, busy4, done4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (done4_cnt !== dc0 || p4 !== 8'h00) begin
      errors++;
      $display("FAIL reset_nodone: pulses=%0d p=%h, required 0 pulses p=00", done4_cnt - dc0, p4);
    end
    run4(1'b1, 4'h7, 4'hF, res, lat);
    exp = exp4_q.pop_front();
    checks++;
    if (res !== exp || lat !== 5) begin
      errors++;
      $display("FAIL reset_after: p=%h lat=%0d, required p=%h lat=5", res, lat, exp);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] res, exp;
    int lat, dc0, off, idx, bad;
    @(posedge clk); #1;
    dc0 = done4_cnt;
    off = int'($urandom_range(511, 0));
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      idx = (i + off) % 512;
      run4(idx[8], idx[7:4], idx[3:0], res, lat);
      exp = exp4_q.pop_front();
      checks++;
      if (res !== exp || lat !== 5) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL sweep sm=%b a=%h b=%h: p=%h lat=%0d, required p=%h lat=5",
                   idx[8], idx[7:4], idx[3:0], res, lat, exp);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (done4_cnt - dc0 !== 512) begin
      errors++;
      $display("FAIL sweep_pulses: done pulses=%0d, required 512", done4_cnt - dc0);
    end
  endtask

  initial begin
    start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    rst_n = 1'b0;
    test_reset();
    test_signed_basic();
    test_corners4();
    test_width8();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
